// File: rtl/interrupt_request_controller.sv
// rtl/interrupt_request_controller.sv - interrupt source latching, prioritisation and handler handshake
// Presents one request per service window at instruction boundaries with vector and type.
module interrupt_request_controller #(
   parameter int SYNC_STAGES  = 2,
   parameter int DONE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        soft_reset_n,
   input  logic        irq_n,
   input  logic [7:0]  ppu_status,
   input  logic        ppu_nmi_enable,
   input  logic        break_flag,
   input  logic [7:0]  status_in,
   input  logic        instr_boundary,
   input  logic        int_done,
   output logic        int_req,
   output logic [2:0]  int_type,
   output logic [15:0] vector_addr,
   output logic        push_b_flag,
   output logic [2:0]  pending,
   output logic        busy,
   output logic        timeout_err
);

   localparam int CW = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DONE_TIMEOUT - 1);

   localparam logic [2:0] T_NONE  = 3'd0;
   localparam logic [2:0] T_RESET = 3'd1;
   localparam logic [2:0] T_NMI   = 3'd2;
   localparam logic [2:0] T_BRK   = 3'd3;
   localparam logic [2:0] T_IRQ   = 3'd4;

   typedef enum logic [1:0] {IDLE, WAIT_DONE, COOLDOWN} state_t;

   state_t                 state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [SYNC_STAGES-1:0] soft_sync, irq_sync;
   logic                   soft_prev, nmi_src, nmi_src_q;
   logic                   reset_pending, nmi_pending, irq_level;
   logic                   soft_fall, nmi_edge, clr_reset, clr_nmi;
   logic                   int_req_nx, push_b_nx, timeout_nx;
   logic [2:0]             int_type_nx;
   logic [15:0]            vector_nx;
   logic                   unused_bits;

   assign unused_bits = ^{ppu_status[6:0], status_in[7:3], status_in[1:0]};

   assign soft_fall = soft_prev & ~soft_sync[SYNC_STAGES-1];
   assign nmi_src   = ppu_status[7] & ppu_nmi_enable;
   // Enabling NMI while vblank is already high is deliberately seen as an edge.
   assign nmi_edge  = nmi_src & ~nmi_src_q;
   assign irq_level = ~irq_sync[SYNC_STAGES-1] & ~status_in[2];
   assign pending   = {irq_level, nmi_pending, reset_pending};
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         soft_sync     <= '1;
         irq_sync      <= '1;
         soft_prev     <= 1'b1;
         nmi_src_q     <= 1'b0;
         reset_pending <= 1'b1;
         nmi_pending   <= 1'b0;
      end else begin
         soft_sync     <= {soft_sync[SYNC_STAGES-2:0], soft_reset_n};
         irq_sync      <= {irq_sync[SYNC_STAGES-2:0], irq_n};
         soft_prev     <= soft_sync[SYNC_STAGES-1];
         nmi_src_q     <= nmi_src;
         // A new edge in the launch cycle outlives the clear.
         reset_pending <= soft_fall | (reset_pending & ~clr_reset);
         nmi_pending   <= nmi_edge | (nmi_pending & ~clr_nmi);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         int_req     <= 1'b0;
         int_type    <= T_NONE;
         vector_addr <= 16'h0000;
         push_b_flag <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         int_req     <= int_req_nx;
         int_type    <= int_type_nx;
         vector_addr <= vector_nx;
         push_b_flag <= push_b_nx;
         timeout_err <= timeout_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      int_req_nx  = 1'b0;
      int_type_nx = int_type;
      vector_nx   = vector_addr;
      push_b_nx   = push_b_flag;
      timeout_nx  = timeout_err;
      clr_reset   = 1'b0;
      clr_nmi     = 1'b0;
      case (state)
         IDLE: begin
            if (instr_boundary && (reset_pending || nmi_pending || break_flag || irq_level)) begin
               int_req_nx = 1'b1;
               state_nx   = WAIT_DONE;
               cnt_nx     = '0;
               push_b_nx  = 1'b0;
               if (reset_pending) begin
                  int_type_nx = T_RESET;
                  vector_nx   = 16'hFFFC;
                  clr_reset   = 1'b1;
               end else if (nmi_pending) begin
                  int_type_nx = T_NMI;
                  vector_nx   = 16'hFFFA;
                  clr_nmi     = 1'b1;
               end else if (break_flag) begin
                  int_type_nx = T_BRK;
                  vector_nx   = 16'hFFFE;
                  push_b_nx   = 1'b1;
               end else begin
                  int_type_nx = T_IRQ;
                  vector_nx   = 16'hFFFE;
               end
            end
         end
         WAIT_DONE: begin
            if (int_done || cnt == CNT_MAX) begin
               state_nx    = int_done ? COOLDOWN : IDLE;
               timeout_nx  = timeout_err | ~int_done;
               int_type_nx = T_NONE;
               vector_nx   = 16'h0000;
               push_b_nx   = 1'b0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         COOLDOWN: begin
            // This boundary only retires the cooldown; it never launches.
            if (instr_boundary) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/interrupt_request_controller.md
Name: interrupt_request_controller

Overview:
- Upstream of the CPU interrupt handler: collects raw interrupt sources, synchronises them, detects edges, latches them, and prioritises them.
- Presents one request to the handler at a time, with vector address and type, only at instruction boundaries.
- Tracks the handler's done pulse and enforces one executed instruction between back-to-back services.
- Sole owner of pending-interrupt state; the handler consumes int_req/vector_addr.

Parameters:
SYNC_STAGES, 2, flip-flop depth for the asynchronous inputs soft_reset_n and irq_n (minimum 2)
DONE_TIMEOUT, 64, max cycles in WAIT_DONE before abort and timeout_err

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
soft_reset_n  in  1  console reset button, active-low, asynchronous
irq_n  in  1  APU/mapper IRQ line, active-low level, asynchronous
ppu_status  in  8  PPU status; bit7 = vblank
ppu_nmi_enable  in  1  PPUCTRL bit7
break_flag  in  1  IE is executing BRK (valid when instr_boundary=1)
status_in  in  8  CPU P register; bit2 = I (IRQ disable)
instr_boundary  in  1  IE at instruction boundary, 1-cycle pulse
int_done  in  1  handler done pulse
int_req  out  1  1-cycle start pulse to handler
int_type  out  3  0 none, 1 reset, 2 nmi, 3 brk, 4 irq; held until WAIT_DONE exits
vector_addr  out  16  low-byte vector address: FFFC/FFFA/FFFE/FFFE; held with int_type
push_b_flag  out  1  1 when int_type=brk (B bit of pushed status)
pending  out  3  {irq_level, nmi_pending, reset_pending}
busy  out  1  state != IDLE
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset (rst=1, async): state=IDLE; int_req=0; int_type=0; vector_addr=0; push_b_flag=0; busy=0; timeout_err=0; nmi_pending=0; sync chains loaded inactive (1).
- reset_pending=1 out of reset (power-on reset vector). pending reads 3'b001 while rst is asserted.
- Synchronisers: soft_reset_n and irq_n each pass through SYNC_STAGES flops.
- reset_pending is set on the falling edge of synced soft_reset_n.
- irq_level = ~irq_n_sync & ~status_in[2]. It is combinational, never latched, and re-evaluated each boundary.
- NMI source nmi_src = ppu_status[7] & ppu_nmi_enable, registered once. A 0->1 transition sets nmi_pending. Enabling NMI during vblank counts as an edge.
- Latch clears happen on the cycle int_req fires for that type. A set in the same cycle wins (a new edge is never lost).
- Priority at launch: reset > nmi > brk > irq. BRK ignores the I flag.
- States:
  - IDLE: on instr_boundary with any request -> drive int_type, vector_addr, push_b_flag; int_req=1 for exactly that cycle; -> WAIT_DONE. No request -> stay in IDLE.
  - WAIT_DONE: counter increments from 0. int_done -> COOLDOWN, int_type=0. Counter reaching DONE_TIMEOUT-1 without int_done -> timeout_err=1, int_type=0, -> IDLE. Pending latches are untouched except the one already cleared.
  - COOLDOWN: ignore requests; next instr_boundary -> IDLE. A boundary is consumed here and cannot launch an interrupt. That boundary's break_flag is dropped (BRK is not latched).
- Latency: boundary cycle with request -> int_req on the same clock edge (registered output asserted the following cycle). vector_addr and int_type are valid in the same cycle as int_req.
- Sources arriving in WAIT_DONE/COOLDOWN: nmi/reset stay latched and are serviced at the first boundary after COOLDOWN. irq is serviced only if still asserted and I=0 then.
- int_done outside WAIT_DONE: ignored.
- instr_boundary while busy outside COOLDOWN: ignored.
- rst mid-service: immediate return to reset values; the in-flight request is abandoned.

Test Plan:
1. Release rst, pulse instr_boundary -> int_req 1 cycle, int_type=1, vector_addr=16'hFFFC, pending[0] clears; int_done -> COOLDOWN; next boundary -> IDLE, busy=0.
2. ppu_nmi_enable=1, ppu_status=8'h80 held 100 cycles, three boundaries -> exactly one NMI, vector_addr=16'hFFFA; toggle enable 0->1 with vblank high -> second NMI.
3. irq_n=0 with status_in=8'h04 -> no request over 20 boundaries; status_in=8'h00 -> int_type=4, vector FFFE, push_b_flag=0.
4. Same boundary: nmi_pending=1, break_flag=1, irq_n=0, I=0 -> NMI first; after COOLDOWN -> IRQ (BRK dropped). Repeat with break_flag on a fresh boundary -> int_type=3, push_b_flag=1.
5. NMI edge during WAIT_DONE of an IRQ -> pending[1]=1; serviced at the second boundary after int_done (first consumed by COOLDOWN).
6. No int_done for 64 cycles -> timeout_err=1, back to IDLE. Assert rst mid-WAIT_DONE -> all outputs at reset values, pending=3'b001.
